// File: rtl/uvme_st_loopback_pkg.sv
// uvme_st_loopback_pkg
// Shared types and sizing helpers for the self-test loopback stage.
//   lb_state_e        : loopback FSM state (CUT, SF_HOLD, SF_FORCE)
//   lb_ptr_width()    : buffer pointer width for a given depth
//   lb_level_width()  : width of a 0..DEPTH occupancy count
package uvme_st_loopback_pkg;

  typedef enum logic [1:0] {
    CUT      = 2'd0,
    SF_HOLD  = 2'd1,
    SF_FORCE = 2'd2
  } lb_state_e;

  function automatic int lb_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full buffer (DEPTH) is representable.
  function automatic int lb_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uvme_st_loopback_fifo.sv
// uvme_st_loopback_fifo
// Word + last-flag storage for the loopback stage.
//   clk, reset            : clock, synchronous active-high reset
//   push, push_data/last  : write one entry (caller guarantees not full)
//   pop                   : retire the head entry (caller guarantees not empty)
//   head_data, head_last  : current head entry (stale but stable when empty)
//   level                 : number of entries held, 0..DEPTH
module uvme_st_loopback_fifo
  import uvme_st_loopback_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              push_last,
  input  logic                              pop,
  output logic [DATA_WIDTH-1:0]             head_data,
  output logic                              head_last,
  output logic [lb_level_width(DEPTH)-1:0]  level
);

  localparam int PW = lb_ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  last_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Storage, pointers and occupancy. The array is cleared on reset so the
  // head reads as zero afterwards and no pre-reset word can ever resurface.
  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/uvme_st_loopback.sv
// uvme_st_loopback
// Self-test loopback: TX words are buffered and replayed on RX, either
// cut-through or store-and-forward (whole packets), with a sticky flag when
// an oversize SF packet has to be force-released.
//   clk, reset                 : clock, synchronous active-high reset
//   cfg_sf_mode                : 0 cut-through, 1 store-and-forward (taken while empty)
//   tx_valid/ready/data/last   : TX stream into the buffer
//   rx_valid/ready/data/last   : RX stream out of the buffer
//   level                      : words currently buffered
//   err_force_release          : sticky oversize-packet flag
//   err_clear                  : one-cycle pulse clearing the flag
module uvme_st_loopback
  import uvme_st_loopback_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_sf_mode,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic [DATA_WIDTH-1:0]             tx_data,
  input  logic                              tx_last,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [DATA_WIDTH-1:0]             rx_data,
  output logic                              rx_last,
  output logic [lb_level_width(DEPTH)-1:0]  level,
  output logic                              err_force_release,
  input  logic                              err_clear
);

  localparam int                LW         = lb_level_width(DEPTH);
  localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);

  lb_state_e     state;
  logic [LW-1:0] pkt_cnt;
  logic          push;
  logic          pop;
  logic          force_trip;

  // tx_ready comes only from the registered level, so a pop in the same
  // cycle never frees space early and rx_ready has no path to tx_ready.
  assign tx_ready = ~reset & (level != FULL_LEVEL);
  assign push     = tx_valid & tx_ready;
  assign pop      = rx_valid & rx_ready;

  // An SF packet that fills the buffer without a last word would deadlock,
  // so it is released as a stream instead.
  assign force_trip = (state == SF_HOLD) && (level == FULL_LEVEL) && (pkt_cnt == '0);

  uvme_st_loopback_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (tx_data),
    .push_last (tx_last),
    .pop       (pop),
    .head_data (rx_data),
    .head_last (rx_last),
    .level     (level)
  );

  // RX gating: stream modes show anything buffered, hold mode only once a
  // complete packet is inside. Inputs are all registered state.
  always_comb begin
    rx_valid = 1'b0;
    case (state)
      CUT, SF_FORCE: rx_valid = (level != '0);
      SF_HOLD:       rx_valid = (pkt_cnt != '0);
      default:       rx_valid = 1'b0;
    endcase
  end

  // Mode FSM, complete-packet count and sticky error flag. The mode is only
  // re-latched while the buffer is idle and empty so a packet never changes
  // mode halfway. pkt_cnt counts buffered last flags in every state, so it
  // is already correct when a forced release hands back to SF_HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= CUT;
      pkt_cnt           <= '0;
      err_force_release <= 1'b0;
    end else begin
      if ((level == '0) && !push) begin
        state <= cfg_sf_mode ? SF_HOLD : CUT;
      end else begin
        case (state)
          SF_HOLD:  if (force_trip)        state <= SF_FORCE;
          SF_FORCE: if (pop && rx_last)    state <= SF_HOLD;
          default:                         state <= state;
        endcase
      end

      case ({push && tx_last, pop && rx_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase

      // A new error outranks a simultaneous clear.
      if (force_trip) begin
        err_force_release <= 1'b1;
      end else if (err_clear) begin
        err_force_release <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uvme_st_loopback.md
# uvme_st_loopback

Self-test loopback stage that sits between the transmit and receive agent interfaces of the self-test environment. Words driven on the TX stream are buffered and returned on the RX stream, so the environment checker always has a live, well-behaved RX counterpart to compare against. Supports cut-through and store-and-forward (packet) modes and reports sticky error flags for the checker and scoreboard.

## Interface
- DATA_WIDTH, 32: payload width of tx_data/rx_data.
- DEPTH, 8: buffer depth in words; power of two, >= 2.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one cycle asserted fully clears the block.
- cfg_sf_mode  in  1  0 = cut-through, 1 = store-and-forward; sampled only while buffer empty.
- tx_valid  in  1  TX word valid.
- tx_ready  out  1  block can accept a TX word.
- tx_data  in  DATA_WIDTH  TX payload.
- tx_last  in  1  final word of packet.
- rx_valid  out  1  RX word valid.
- rx_ready  in  1  RX consumer accepts word.
- rx_data  out  DATA_WIDTH  RX payload.
- rx_last  out  1  final word of packet.
- level  out  $clog2(DEPTH)+1  words currently buffered.
- err_force_release  out  1  sticky: SF packet exceeded DEPTH and was force-released.
- err_clear  in  1  clears sticky error flag (single-cycle pulse).

## Operation
- Push on tx_valid && tx_ready; pop on rx_valid && rx_ready. Word and last flag stored together.
- tx_ready = (level != DEPTH). Full buffer refuses a push even if a pop occurs the same cycle.
- Empty buffer: push and pop cannot coincide (rx_valid low); no bypass path.
- FSM states (shared-package enum): CUT, SF_HOLD, SF_FORCE.
  - Mode latch: when level == 0 and no push this cycle, state <= cfg_sf_mode ? SF_HOLD : CUT.
  - CUT: rx_valid = (level != 0).
  - SF_HOLD: rx_valid = (pkt_cnt != 0); pkt_cnt increments on push with tx_last, decrements on pop with rx_last; simultaneous both -> unchanged.
  - SF_HOLD -> SF_FORCE when level == DEPTH and pkt_cnt == 0; sets err_force_release.
  - SF_FORCE: behaves as CUT until a word with last is popped, then -> SF_HOLD.
- err_clear and a new error in the same cycle: error wins (flag stays 1).
- Pointers are $clog2(DEPTH) bits and wrap naturally; level tracked separately, range 0..DEPTH.
- rx_data/rx_last driven from buffer head; value undefined-but-stable (previous head) when rx_valid low.
- Once rx_valid is high it stays high with stable rx_data/rx_last until popped.

## Timing
- Reset values: tx_ready 0 during reset, 1 from first cycle after; rx_valid 0, rx_data 0, rx_last 0, level 0, err_force_release 0, state CUT, pkt_cnt 0.
- Cut-through latency: word pushed in cycle N visible on RX in cycle N+1.
- SF latency: first word visible the cycle after its packet's last word is pushed.
- Throughput: one word per cycle sustained in both modes when rx_ready held high.
- level updates the cycle after push/pop; tx_ready derived from registered level (no combinational path rx_ready -> tx_ready).
- Reset mid-packet discards buffer contents and pkt_cnt; no partial word is emitted after reset.

## Structure
- uvme_st_loopback_pkg: state enum (CUT, SF_HOLD, SF_FORCE), depth/width localparam helpers.
- One sub-module: uvme_st_loopback_fifo (storage, pointers, level, push/pop); top holds FSM, pkt_cnt, error flag, valid gating.

## Test plan
- Cut-through, rx_ready=1, push 0x11,0x22,0x33 back-to-back -> same words on RX cycles N+1..N+3, level never exceeds 1.
- Fill: rx_ready=0, push 8 words (DEPTH=8) -> tx_ready drops after 8th, level=8; rx_ready=1 with tx_valid=1 on full -> no push that cycle, one pop.
- SF mode, 3-word packet last on 0xC -> rx_valid stays 0 until cycle after 0xC accepted, then 0xA,0xB,0xC with rx_last on 0xC.
- SF mode, 10-word packet (DEPTH=8) with rx_ready=1 -> force release at level 8, err_force_release=1, all 10 words delivered in order, return to SF_HOLD after last.
- err_clear pulse coinciding with a new force release -> flag remains 1; isolated err_clear -> 0 next cycle.
- Assert reset with 5 words buffered mid-packet -> next cycle level=0, rx_valid=0, tx_ready=1 after deassert; a subsequent packet passes unaltered.
